// File: rtl/matrix_calc_driver_if.sv
// matrix_calc_driver_if: byte-serial link between matrix_calc_driver and the matrix calculator.
interface matrix_calc_driver_if;
    logic [7:0] calc_data_in;
    logic       calc_enter;
    logic       calc_sw;
    logic [1:0] calc_operation;
    logic       calc_rst;
    logic [5:0] calc_data_out;
    logic       calc_finish;
    logic       calc_error;
    logic [3:0] calc_index;
    modport master (
        output calc_data_in, calc_enter, calc_sw, calc_operation, calc_rst,
        input  calc_data_out, calc_finish, calc_error, calc_index
    );
    modport slave (
        input  calc_data_in, calc_enter, calc_sw, calc_operation, calc_rst,
        output calc_data_out, calc_finish, calc_error, calc_index
    );
endinterface

// File: rtl/matrix_calc_driver.sv
// matrix_calc_driver: loads matrices A and B byte by byte into the calculator and reads back 16 result words.
// Define MATRIX_CALC_DRIVER_TIMEOUT_EN to fault after TIMEOUT_CYCLES of waiting on the calculator.
module matrix_calc_driver #(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          operand_a,
    input  logic [31:0]          operand_b,
    input  logic [1:0]           op,
    matrix_calc_driver_if.master calc,
    output logic [95:0]          result,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code
);
    typedef enum logic [3:0] {
        IDLE, CRST, SETTLE, ENT_HI, ENT_LO, WAIT_CALC, CAPTURE, SW_HI, SW_LO, DONE, FAULT
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("matrix_calc_driver: GAP_CYCLES or TIMEOUT_CYCLES out of range");
    end

    state_t      state;
    logic [63:0] ops;
    logic [2:0]  b;
    logic [3:0]  k;
    logic [3:0]  g;
    logic        crst;
    logic        accept;
`ifdef MATRIX_CALC_DRIVER_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wcnt;
`endif

    assign accept = start && (state == IDLE || state == DONE || state == FAULT);
    // The calculator must see reset for as long as our own reset is held, not just from the next edge.
    assign calc.calc_rst = crst | rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            ops                 <= '0;
            b                   <= '0;
            k                   <= '0;
            g                   <= '0;
            crst                <= 1'b0;
            result              <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            error               <= 1'b0;
            err_code            <= 2'b00;
            calc.calc_enter     <= 1'b0;
            calc.calc_sw        <= 1'b0;
            calc.calc_data_in   <= '0;
            calc.calc_operation <= 2'b00;
`ifdef MATRIX_CALC_DRIVER_TIMEOUT_EN
            wcnt                <= '0;
`endif
        end else if (accept) begin
            state               <= CRST;
            ops                 <= {operand_a, operand_b};
            calc.calc_operation <= op;
            crst                <= 1'b1;
            busy                <= 1'b1;
            done                <= 1'b0;
            error               <= 1'b0;
            err_code            <= 2'b00;
            b                   <= '0;
            k                   <= '0;
        end else begin
            case (state)
                CRST: begin
                    crst  <= 1'b0;
                    state <= SETTLE;
                end
                SETTLE: begin
                    state             <= ENT_HI;
                    calc.calc_enter   <= 1'b1;
                    calc.calc_data_in <= ops[63:56];
                    ops               <= {ops[55:0], 8'h00};
                end
                ENT_HI: begin
                    state           <= ENT_LO;
                    calc.calc_enter <= 1'b0;
                    g               <= '0;
                end
                ENT_LO: begin
                    if (g != GAP_LAST) g <= g + 4'd1;
                    else if (b == 3'd7) begin
                        state <= WAIT_CALC;
`ifdef MATRIX_CALC_DRIVER_TIMEOUT_EN
                        wcnt  <= '0;
`endif
                    end else begin
                        b                 <= b + 3'd1;
                        state             <= ENT_HI;
                        calc.calc_enter   <= 1'b1;
                        calc.calc_data_in <= ops[63:56];
                        ops               <= {ops[55:0], 8'h00};
                    end
                end
                WAIT_CALC: begin
                    if (calc.calc_error) begin
                        state    <= FAULT;
                        error    <= 1'b1;
                        err_code <= 2'b01;
                        busy     <= 1'b0;
                    end else if (calc.calc_finish) begin
                        state <= CAPTURE;
                        k     <= '0;
`ifdef MATRIX_CALC_DRIVER_TIMEOUT_EN
                        wcnt  <= '0;
                    end else if (wcnt == WAIT_LAST) begin
                        state    <= FAULT;
                        error    <= 1'b1;
                        err_code <= 2'b10;
                        busy     <= 1'b0;
                    end else begin
                        wcnt <= wcnt + 16'd1;
`endif
                    end
                end
                CAPTURE: begin
                    if (calc.calc_index == k) begin
                        result[95 - 6 * int'(k) -: 6] <= calc.calc_data_out;
                        if (k == 4'd15) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state        <= SW_HI;
                            calc.calc_sw <= 1'b1;
                        end
`ifdef MATRIX_CALC_DRIVER_TIMEOUT_EN
                    end else if (wcnt == WAIT_LAST) begin
                        state    <= FAULT;
                        error    <= 1'b1;
                        err_code <= 2'b10;
                        busy     <= 1'b0;
                    end else begin
                        wcnt <= wcnt + 16'd1;
`endif
                    end
                end
                SW_HI: begin
                    state        <= SW_LO;
                    calc.calc_sw <= 1'b0;
                    g            <= '0;
                end
                SW_LO: begin
                    if (g != GAP_LAST) g <= g + 4'd1;
                    else begin
                        k     <= k + 4'd1;
                        state <= CAPTURE;
`ifdef MATRIX_CALC_DRIVER_TIMEOUT_EN
                        wcnt  <= '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_calc_driver.sv
// tb_matrix_calc_driver: randomized transactions against a timeline model of the driver plus a calculator model.
// Build with MATRIX_CALC_DRIVER_TIMEOUT_EN defined to also exercise the timeout fault.
module tb_matrix_calc_driver;
    localparam int G        = 2;
    localparam int TO       = 20;
    localparam int L        = G + 1;
    localparam int LOAD_END = 3 + 8 * L;
    localparam int BIG      = 1 << 30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [1:0]  op = '0;
    logic [95:0] result;
    logic        busy, done, error;
    logic [1:0]  err_code;

    matrix_calc_driver_if bus ();

    matrix_calc_driver #(.GAP_CYCLES(G), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .operand_a(operand_a), .operand_b(operand_b), .op(op),
        .calc(bus), .result(result), .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        active = 1'b0;
    logic        ended = 1'b0;
    int          c = 0;
    int          mode = 0;
    int          fin_at = 0;
    int          win = 0;
    int          rdy = 0;
    int          pend = -1;
    int          sw_count = 0;
    logic        sw_prev = 1'b0;
    logic [63:0] exp_ops = '0;
    logic [63:0] seen = '0;
    logic [1:0]  exp_op = '0;
    logic [95:0] exp_result = '0;
    logic [5:0]  words [16];
    int          lat [16];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    task automatic finish_txn();
        active = 1'b0;
        ended  = 1'b1;
    endtask

    // Expected outputs from cycle offset c after acceptance: CRST at 1, SETTLE at 2, byte j/L of the load from 3.
    task automatic check_cycle();
        logic [4:0]  st;
        logic [95:0] r;
        int          j, ev;
        st = {busy, done, error, err_code};
        chk("operation", bus.calc_operation, exp_op);
        if (c == 1) chk("crst", {bus.calc_rst, bus.calc_enter, bus.calc_sw, st}, {3'b100, 5'b10000});
        else if (c == 2) chk("settle", {bus.calc_rst, bus.calc_enter, bus.calc_sw, st}, {3'b000, 5'b10000});
        else if (c < LOAD_END) begin
            j = c - 3;
            chk("load", {bus.calc_rst, bus.calc_enter, bus.calc_sw, bus.calc_data_in, st},
                {1'b0, (j % L == 0), 1'b0, exp_ops[63 - 8 * (j / L) -: 8], 5'b10000});
            if (bus.calc_enter) seen = {seen[55:0], bus.calc_data_in};
        end else begin
            if (c == LOAD_END) chk("bytes", seen, exp_ops);
            chk("quiet", {bus.calc_rst, bus.calc_enter}, 2'b00);
            ev = (win > rdy ? win : rdy) + 1;
            if (c > 4000) begin
                chk("cycle_budget", {done, error}, 2'b10);
                finish_txn();
            end else if (mode == 1 && c == fin_at + 1) begin
                chk("fault", {st, bus.calc_sw}, {5'b00101, 1'b0});
                chk("fault_result", result, exp_result);
                chk("fault_sw", sw_count, 0);
                finish_txn();
            end else if (mode == 2 && c == LOAD_END + TO) begin
                chk("timeout", {st, bus.calc_sw}, {5'b00110, 1'b0});
                chk("timeout_sw", sw_count, 0);
                finish_txn();
            end else if (mode == 0 && c == ev) begin
                if (sw_count == 15) begin
                    for (int w = 0; w < 16; w++) r[95 - 6 * w -: 6] = words[w];
                    exp_result = r;
                    chk("done", {st, bus.calc_sw}, {5'b01000, 1'b0});
                    chk("result", result, r);
                    chk("index", bus.calc_index, 4'd15);
                    finish_txn();
                end else chk("sw_rise", {st, bus.calc_sw}, {5'b10000, 1'b1});
            end else chk("busy", {st, bus.calc_sw}, {5'b10000, 1'b0});
        end
    endtask

    // Calculator: index advances lat[k] cycles after each rising calc_sw, finish/error rise at fin_at.
    task automatic calc_step();
        if (bus.calc_rst) begin
            bus.calc_index  = '0;
            bus.calc_finish = 1'b0;
            bus.calc_error  = 1'b0;
            pend            = -1;
            sw_prev         = 1'b0;
        end else begin
            if (active && c == fin_at) begin
                bus.calc_finish = (mode != 2);
                bus.calc_error  = (mode == 1);
            end
            if (pend == 0) begin
                bus.calc_index = bus.calc_index + 4'd1;
                rdy  = c;
                pend = -1;
            end else if (pend > 0) pend--;
            if (bus.calc_sw && !sw_prev) begin
                sw_count++;
                win  = c + G + 1;
                rdy  = BIG;
                pend = lat[sw_count];
            end
            sw_prev = bus.calc_sw;
        end
        bus.calc_data_out = words[bus.calc_index];
    endtask

    initial begin
        for (int w = 0; w < 16; w++) begin
            words[w] = 6'(w);
            lat[w]   = 0;
        end
        bus.calc_finish   = 1'b0;
        bus.calc_error    = 1'b0;
        bus.calc_index    = '0;
        bus.calc_data_out = '0;
        forever begin
            @(negedge clk);
            if (active) begin
                c++;
                check_cycle();
            end
            calc_step();
        end
    end

    task automatic begin_txn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                             input int md, input int fdel);
        @(negedge clk);
        #1;
        operand_a = a;
        operand_b = b;
        op        = o;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        operand_a = ~a;
        operand_b = ~b;
        op        = ~o;
        exp_ops   = {a, b};
        exp_op    = o;
        mode      = md;
        fin_at    = LOAD_END + fdel;
        win       = fin_at + 1;
        rdy       = 1;
        pend      = -1;
        sw_count  = 0;
        seen      = '0;
        ended     = 1'b0;
        c         = 0;
        active    = 1'b1;
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                           input int md, input int fdel, input int stray);
        begin_txn(a, b, o, md, fdel);
        if (stray > 0) begin
            wait (c == stray);
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait (ended);
    endtask

    task automatic randomize_calc();
        for (int w = 0; w < 16; w++) begin
            words[w] = 6'($urandom);
            lat[w]   = $urandom_range(0, 3);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_state", {busy, done, error, err_code, bus.calc_enter, bus.calc_sw, bus.calc_data_in,
                            bus.calc_operation, bus.calc_rst, result}, {5'b0, 2'b0, 8'h0, 2'b0, 1'b1, 96'h0});
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_release", {bus.calc_rst, busy}, 2'b00);

        // basic load and readback with word k = k; a start while busy must be ignored
        for (int w = 0; w < 16; w++) lat[w] = $urandom_range(0, 3);
        run_txn(32'h12345678, 32'h9ABCDEF0, 2'b10, 0, 3, 10);
        chk("bytes_literal", seen, 64'h123456789ABCDEF0);
        chk("result_literal", result, {6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                                       6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15});
        chk("sw_literal", sw_count, 15);

        // calculator error (with finish also high) started from DONE
        run_txn($urandom, $urandom, 2'b01, 1, 0, 0);
        chk("err_literal", {done, error, err_code}, 4'b0101);
        chk("err_sw_literal", sw_count, 0);

`ifdef MATRIX_CALC_DRIVER_TIMEOUT_EN
        run_txn($urandom, $urandom, 2'b11, 2, 0, 0);
        chk("timeout_literal", {error, err_code}, 3'b110);
`else
        randomize_calc();
        run_txn($urandom, $urandom, 2'b11, 0, 40, 0);
        chk("no_timeout_literal", {done, err_code}, 3'b100);
`endif

        // reset during the 4th ENT_LO, then a full transaction from IDLE
        begin_txn($urandom, $urandom, 2'b10, 0, 5);
        wait (c == 3 + 3 * L + 1);
        #2 rst = 1'b1;
        #1 chk("rst_async", {busy, done, error, err_code, bus.calc_enter, bus.calc_sw, bus.calc_data_in,
                             bus.calc_operation, bus.calc_rst, result}, {5'b0, 2'b0, 8'h0, 2'b0, 1'b1, 96'h0});
        active     = 1'b0;
        ended      = 1'b1;
        exp_result = '0;
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_release_mid", {bus.calc_rst, busy, bus.calc_operation}, 4'b0000);
        randomize_calc();
        run_txn($urandom, $urandom, 2'b01, 0, 2, 0);

        for (int t = 0; t < 12; t++) begin
            randomize_calc();
            run_txn($urandom, $urandom, 2'($urandom), ($urandom_range(0, 4) == 0) ? 1 : 0,
                    $urandom_range(0, 10), ($urandom_range(0, 1) == 1) ? $urandom_range(1, LOAD_END) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
